// File: rtl/tdm_demux4.sv
// tdm_demux4: 4-slot serial TDM demultiplexer; optional even-parity frame check via TDM_PARITY_EN
module tdm_demux4 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       din,
   input  logic       din_valid,
   input  logic       frame_sync,
   output logic [3:0] out,
   output logic       frame_done,
   output logic [1:0] slot,
   output logic       err,
   output logic [9:0] LED
);
`ifdef TDM_PARITY_EN
   typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
`else
   typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif
   state_t     state;
   logic [3:0] shadow;
   logic [3:0] shadow_nxt;
   // shadow with the current bit merged into its slot, so a completing frame can load out directly
   always_comb begin
      shadow_nxt       = shadow;
      shadow_nxt[slot] = din;
   end
   // frame FSM: sync always (re)starts a frame; valid bits advance the slot; the last bit completes it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         shadow     <= 4'b0;
         out        <= 4'b0;
         slot       <= 2'd0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (din_valid) begin
            if (frame_sync) begin
               shadow <= {3'b0, din};
               slot   <= 2'd1;
               state  <= RECV;
            end else if (state == RECV) begin
               shadow <= shadow_nxt;
               slot   <= slot + 2'd1;
`ifdef TDM_PARITY_EN
               if (slot == 2'd3) state <= CHECK;
`else
               if (slot == 2'd3) begin
                  out        <= shadow_nxt;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
`endif
            end
`ifdef TDM_PARITY_EN
            else if (state == CHECK) begin
               state <= IDLE;
               if (^{shadow, din} == 1'b0) begin
                  out        <= shadow;
                  frame_done <= 1'b1;
                  err        <= 1'b0;
               end else begin
                  err <= 1'b1;
               end
            end
`endif
         end
      end
   end
   assign LED = {2'b00, state != IDLE, err, slot, out};
endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have these ports:
- clk, input, 1 bit: single clock; all state changes on the rising edge.
- reset_n, input, 1 bit: asynchronous, active-low reset.
- din, input, 1 bit: serial time-division data bit.
- din_valid, input, 1 bit: din is sampled only on edges where din_valid=1.
- frame_sync, input, 1 bit: qualified by din_valid; marks the current din as slot-0 of a new frame.
- out, output, 4 bits: last accepted frame; out[n] is the channel-n bit.
- frame_done, output, 1 bit: one-cycle pulse when out is updated.
- slot, output, 2 bits: index of the next slot expected.
- err, output, 1 bit: parity error flag.
- LED, output, 10 bits: board indicators.
REQ-002 All outputs SHALL be registered, except LED, which SHALL be a direct combinational mapping of registered signals.

Function
REQ-003 The FSM SHALL have states IDLE, RECV and, with the parity build only, CHECK.
REQ-004 In IDLE, din_valid=1 with frame_sync=1 SHALL store din as shadow[0], set slot=1 and enter RECV.
REQ-005 In IDLE, a valid bit without frame_sync SHALL be ignored (no state change).
REQ-006 In RECV, din_valid=1 with frame_sync=0 SHALL store din into shadow[slot] and increment slot.
REQ-007 In RECV, when the slot-3 bit is sampled, the frame SHALL complete: without parity, out is loaded and the FSM returns to IDLE; with parity, the FSM enters CHECK.
REQ-008 In RECV or CHECK, din_valid=1 with frame_sync=1 SHALL abort the partial frame and restart as in REQ-004; out, frame_done and err are unchanged.
REQ-009 din_valid=0 SHALL hold all state indefinitely (no timeout).
REQ-010 Latency: out, and frame_done=1, SHALL become visible in the cycle after the edge that samples the final bit of the frame (slot 3, or the parity bit).
REQ-011 frame_done SHALL be high for exactly one cycle per accepted frame.
REQ-012 out SHALL hold its value until the next accepted frame.
REQ-013 slot SHALL wrap from 3 back to 0 on frame completion.
REQ-014 LED mapping SHALL be: LED[3:0]=out, LED[5:4]=slot, LED[6]=err, LED[7]=(state!=IDLE), LED[9:8]=0.

Reset
REQ-015 When reset_n=0, the block SHALL immediately, with no clock edge needed, set: state=IDLE, shadow=0, out=0, slot=0, frame_done=0, err=0.
REQ-016 Reset asserted mid-frame SHALL discard the partial frame.
REQ-017 After reset release, the first valid bit SHALL be processed normally; a frame_sync is required to start a frame.

Configuration
REQ-018 The parity feature SHALL be controlled by macro TDM_PARITY_EN.
REQ-019 With TDM_PARITY_EN defined:
- Each frame carries a fifth valid bit, the even-parity bit, accepted in CHECK.
- If the XOR of shadow[3:0] and the parity bit is 0: load out, pulse frame_done, clear err.
- Otherwise: keep out, no frame_done, set err=1.
- err stays set until the next good frame or reset.
- The FSM returns to IDLE either way.
REQ-020 Without TDM_PARITY_EN, the CHECK state and its logic SHALL be absent, and err SHALL be constant 0.

Verification
REQ-021 Reset check: assert reset_n=0 between clock edges -> all outputs read 0 immediately.
REQ-022 Basic frame, no parity: valid bits 1(sync),0,1,1 -> out=4'b1101 and frame_done=1 for one cycle, one cycle after the fourth bit; slot returns to 0.
REQ-023 Gaps and resync: same frame with din_valid=0 gaps of 3 cycles between bits -> identical result. Then sync, 1, 1, sync, 0, 0, 0, 1 -> out=4'b1000; the aborted frame produces no frame_done.
REQ-024 Parity build: data 1,0,1,1 plus parity 1 -> out=4'b1101, err=0. Next frame 0,1,0,0 plus parity 0 -> out stays 4'b1101, err=1, no frame_done. Next good frame clears err.
REQ-025 Mid-frame reset: after 2 bits, pulse reset_n low -> slot=0 and state=IDLE. A following unsynced valid bit is ignored.
REQ-026 Ignore before sync: in IDLE, drive 6 valid bits with frame_sync=0 -> slot stays 0, out unchanged, LED[7]=0.
